// File: rtl/io_pkg.sv
// Shared types and defaults for the io_port peripheral.
package io_pkg;

  localparam int WORD_W        = 64;
  localparam int DEFAULT_DEPTH = 8;

  // Output-side drain FSM: PRESENT means a word is being offered to the host.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head word (0 when empty).
// A push while full is taken only if a pop happens in the same cycle.
// DEPTH must be a power of two, minimum 2.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, head masks empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_port.sv
// CPU-side I/O port: input FIFO filled by the host and read by the CPU,
// output FIFO written by the CPU and drained by the host over valid/ready.
// Build option: IO_PORT_LOOPBACK_EN routes CPU writes into the input FIFO
// and disables both host-side streams.
//
//   state   | meaning
//   IDLE    | output FIFO empty, nothing offered to the host
//   PRESENT | head word of output FIFO offered on host_out_*
module io_port
  import io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_signal,
  output logic [WIDTH-1:0] in_data,
  output logic             in_avail,
  input  logic             out_signal,
  input  logic [WIDTH-1:0] out_data,
  input  logic             host_in_valid,
  input  logic [WIDTH-1:0] host_in_data,
  output logic             host_in_ready,
  output logic             host_out_valid,
  output logic [WIDTH-1:0] host_out_data,
  input  logic             host_out_ready,
  input  logic             err_clear,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_push, in_pop, in_empty, in_full;
  logic [WIDTH-1:0] in_push_data, in_head;
  logic [CW-1:0]    in_count_unused;

  logic             out_push, out_pop, out_empty_unused, out_full;
  logic [WIDTH-1:0] out_head;
  logic [CW-1:0]    out_count;

  drain_state_t     state_q, state_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             ovf_evt, udf_evt;

`ifdef IO_PORT_LOOPBACK_EN
  logic unused_lb;
  assign unused_lb = ^{host_in_valid, host_in_data, host_out_ready, out_full};
`endif

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (in_push_data),
    .pop       (in_pop),
    .head      (in_head),
    .empty     (in_empty),
    .full      (in_full),
    .count     (in_count_unused)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_push),
    .push_data (out_data),
    .pop       (out_pop),
    .head      (out_head),
    .empty     (out_empty_unused),
    .full      (out_full),
    .count     (out_count)
  );

  assign in_data       = in_head;
  assign in_avail      = !in_empty;
  assign host_out_data = out_head;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // Steer CPU/host traffic onto the two FIFOs and detect error events.
  always_comb begin
    in_pop  = in_signal && !in_empty;
    udf_evt = in_signal && in_empty;
`ifdef IO_PORT_LOOPBACK_EN
    host_in_ready  = 1'b0;
    host_out_valid = 1'b0;
    in_push        = out_signal;
    in_push_data   = out_data;
    out_push       = 1'b0;
    out_pop        = 1'b0;
    // A write into a full FIFO survives only if the CPU reads in the same cycle.
    ovf_evt        = out_signal && in_full && !in_pop;
`else
    host_in_ready  = !in_full;
    host_out_valid = (state_q == PRESENT);
    in_push        = host_in_valid && !in_full;
    in_push_data   = host_in_data;
    out_push       = out_signal;
    out_pop        = host_out_valid && host_out_ready;
    ovf_evt        = out_signal && out_full && !out_pop;
`endif
  end

  // Drain FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (out_count != '0) state_d = PRESENT;
      PRESENT: if (out_pop && (out_count == CW'(1)) && !out_push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_comb begin
    overflow_d  = (overflow_q && !err_clear) || ovf_evt;
    underflow_d = (underflow_q && !err_clear) || udf_evt;
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
